// File: rtl/pipeline_ctrl.sv
// Pipeline control: run/single-step sequencing, load-use stalls, branch flushes,
// and a three-cycle drain after HALT before the pipeline reports finished.
module pipeline_ctrl #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              mode_step_i,
  input  logic              step_i,
  input  logic              ID_EX_mem_read_i,
  input  logic [NB_REG-1:0] ID_EX_rt_i,
  input  logic [NB_REG-1:0] IF_ID_rs_i,
  input  logic [NB_REG-1:0] IF_ID_rt_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              halt_i,
  output logic              pipe_enable_o,
  output logic              pc_write_o,
  output logic              IF_ID_write_o,
  output logic              ID_EX_bubble_o,
  output logic              IF_ID_flush_o,
  output logic              halted_o,
  output logic [NB_CNT-1:0] stall_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       en, lu, draining, fetch;

  always_comb begin
    draining = (state_q == S_DRAIN);
    lu = ID_EX_mem_read_i && (ID_EX_rt_i != '0) &&
         ((ID_EX_rt_i == IF_ID_rs_i) || (ID_EX_rt_i == IF_ID_rt_i));
    unique case (state_q)
      S_RUN, S_DRAIN: en = 1'b1;
      S_STEP:         en = step_i;
      default:        en = 1'b0;
    endcase
    fetch          = en && !lu && !draining;
    pipe_enable_o  = en;
    pc_write_o     = fetch;
    IF_ID_write_o  = fetch;
    ID_EX_bubble_o = en && (lu || draining);
    // A stalled branch keeps its flush pending until the cycle it really advances.
    IF_ID_flush_o  = fetch && (branch_taken_i || jump_i);
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = mode_step_i ? S_STEP : S_RUN;
      end
      S_RUN, S_STEP: begin
        if (en && halt_i && !lu) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd2) state_d = S_HALTED;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      drain_cnt_q   <= 2'd0;
      halted_o      <= 1'b0;
      stall_count_o <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      halted_o    <= (state_d == S_HALTED);
      if (en && lu && !draining && (stall_count_o != '1))
        stall_count_o <= stall_count_o + 1'b1;
    end
  end

endmodule
